zero_out_channel: RTL and testbench

- Downstream consumer of the interpreter's out channel (the `out` instruction's write stream).
- Buffers each emitted word in a FIFO and streams it to the host or test harness over a valid/ready handshake.
- Tracks the run lifecycle so the harness knows when every output word has been delivered.
- Sits between the instruction-execution core and the FPGA test wrapper or host link.

---
 rtl/zero_out_pkg.sv | 24 ++
 rtl/zero_out_fifo.sv | 62 ++++++
 rtl/zero_out_channel.sv | 105 ++++++++++
 tb/tb_zero_out_channel.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zero_out_pkg.sv
/******************************************************************************
 * Module      : zero_out_pkg
 * Description : Shared types and defaults for the zero out-channel buffer.
 * Revision    : 1.0 - initial release
 ******************************************************************************/
`default_nettype none

package zero_out_pkg;

   localparam int DEFAULT_WIDTH = 12;
   localparam int DEFAULT_DEPTH = 16;

   typedef logic [DEFAULT_WIDTH-1:0] word_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/zero_out_fifo.sv
/******************************************************************************
 * Module      : zero_out_fifo
 * Description : Power-of-two FIFO with wrap-bit pointers, occupancy and full.
 * Revision    : 1.0 - initial release
 ******************************************************************************/
`default_nettype none

module zero_out_fifo #(
   parameter  int WIDTH = 12,
   parameter  int DEPTH = 16,
   localparam int CW    = $clog2(DEPTH) + 1,
   localparam int AW    = CW - 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             push,
   input  logic             ready,
   input  logic [WIDTH-1:0] wdata,
   output logic             valid,
   output logic [WIDTH-1:0] rdata,
   output logic [CW-1:0]    count,
   output logic             full
);

   logic [CW-1:0]    wr_ptr;
   logic [CW-1:0]    rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             empty;
   logic             pop;
   logic             wr_en;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop   = !empty && ready;
   // At full, a push only lands when the head slot is freed in the same cycle.
   assign wr_en = push && (!full || pop);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + CW'(1);
         if (pop)   rd_ptr <= rd_ptr + CW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   assign valid = !empty;
   assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];
   assign count = wr_ptr - rd_ptr;

endmodule

`default_nettype wire

// File: rtl/zero_out_channel.sv
/******************************************************************************
 * Module      : zero_out_channel
 * Description : Buffers interpreter out-channel words, streams them over
 *               valid/ready and tracks run completion. Optional output
 *               checker enabled by macro ZERO_OUT_CHECK_EN.
 * Revision    : 1.0 - initial release
 ******************************************************************************/
`default_nettype none

module zero_out_channel
   import zero_out_pkg::*;
#(
   parameter  int MemoryElementWidth = DEFAULT_WIDTH,
   parameter  int NOut               = DEFAULT_DEPTH,
   localparam int CountWidth         = $clog2(NOut) + 1
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          run,
   input  logic                          outWrite,
   input  logic [MemoryElementWidth-1:0] outData,
   input  logic                          progFinished,
   output logic                          dataValid,
   input  logic                          dataReady,
   output logic [MemoryElementWidth-1:0] data,
   output logic [CountWidth-1:0]         count,
   output logic                          overflow,
`ifdef ZERO_OUT_CHECK_EN
   input  logic [MemoryElementWidth-1:0] expectData,
   output logic                          success,
   output logic [CountWidth-1:0]         mismatches,
`endif
   output logic                          done
);

   state_t state;
   state_t state_next;
   logic   push_ok;
   logic   pop;
   logic   full;

   // run wins over a same-cycle push; the word is discarded.
   assign push_ok = outWrite && !run && ((state == RUN) || (state == DRAIN));
   assign pop     = dataValid && dataReady;

   zero_out_fifo #(
      .WIDTH (MemoryElementWidth),
      .DEPTH (NOut)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .clear (run),
      .push  (push_ok),
      .ready (dataReady),
      .wdata (outData),
      .valid (dataValid),
      .rdata (data),
      .count (count),
      .full  (full)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (run) begin
         state_next = RUN;
      end else begin
         case (state)
            RUN:     if (progFinished) state_next = DRAIN;
            DRAIN:   if ((count == '0) && !push_ok) state_next = DONE;
            default: state_next = state;
         endcase
      end
   end

   always_comb begin
      done = (state == DONE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                          overflow <= 1'b0;
      else if (run)                        overflow <= 1'b0;
      else if (push_ok && full && !pop)    overflow <= 1'b1;
   end

`ifdef ZERO_OUT_CHECK_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         mismatches <= '0;
      else if (run)
         mismatches <= '0;
      else if (pop && (data != expectData) && (mismatches != '1))
         mismatches <= mismatches + CountWidth'(1);
   end

   assign success = done && (mismatches == '0) && !overflow;
`endif

endmodule

`default_nettype wire

// File: tb/tb_zero_out_channel.sv
/******************************************************************************
 * Module      : tb_zero_out_channel
 * Description : Directed self-checking bench for zero_out_channel.
 * Revision    : 1.0 - initial release
 ******************************************************************************/
`default_nettype none

module tb_zero_out_channel;
   import zero_out_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        run;
   logic        outWrite;
   word_t       outData;
   logic        progFinished;
   logic        dataValid;
   logic        dataReady;
   word_t       data;
   logic [4:0]  count;
   logic        overflow;
   logic        done;
`ifdef ZERO_OUT_CHECK_EN
   word_t       expectData;
   logic        success;
   logic [4:0]  mismatches;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   zero_out_channel dut (
      .clock        (clock),
      .reset        (reset),
      .run          (run),
      .outWrite     (outWrite),
      .outData      (outData),
      .progFinished (progFinished),
      .dataValid    (dataValid),
      .dataReady    (dataReady),
      .data         (data),
      .count        (count),
      .overflow     (overflow),
`ifdef ZERO_OUT_CHECK_EN
      .expectData   (expectData),
      .success      (success),
      .mismatches   (mismatches),
`endif
      .done         (done)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_run();
      run = 1'b1;
      tick();
      run = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; run = 1'b0; outWrite = 1'b0; outData = '0;
      progFinished = 1'b0; dataReady = 1'b0;
`ifdef ZERO_OUT_CHECK_EN
      expectData = '0;
`endif
      tick();
      total++;
      if ({dataValid, data, count, overflow, done} !== 19'd0) begin
         bad++;
         $display("FAIL reset_outputs: got v=%b d=%0d c=%0d o=%b dn=%b want all 0",
                  dataValid, data, count, overflow, done);
      end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      pulse_run();
      dataReady = 1'b1; outWrite = 1'b1; outData = 12'd2;
      #1;
      total++;
      if (dataValid !== 1'b0) begin
         bad++; $display("FAIL no_bypass: got valid=%b want 0", dataValid);
      end
      tick();
      outWrite = 1'b0;
      total++;
      if (dataValid !== 1'b1 || data !== 12'd2) begin
         bad++; $display("FAIL basic_head: got v=%b d=%0d want v=1 d=2", dataValid, data);
      end
      progFinished = 1'b1;
      tick();
      total++;
      if (count !== 5'd0 || done !== 1'b0) begin
         bad++; $display("FAIL basic_popped: got c=%0d done=%b want c=0 done=0", count, done);
      end
      tick();
      total++;
      if (done !== 1'b1) begin
         bad++; $display("FAIL basic_done: got done=%b want 1", done);
      end
      progFinished = 1'b0;
   endtask

   task automatic test_overflow();
      pulse_run();
      total++;
      if (done !== 1'b0 || count !== 5'd0) begin
         bad++; $display("FAIL run_clears: got done=%b c=%0d want 0 0", done, count);
      end
      dataReady = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         outWrite = 1'b1; outData = word_t'(i);
         tick();
      end
      total++;
      if (count !== 5'd16 || overflow !== 1'b0) begin
         bad++; $display("FAIL fill_16: got c=%0d o=%b want c=16 o=0", count, overflow);
      end
      outData = 12'd17;
      tick();
      outWrite = 1'b0;
      total++;
      if (count !== 5'd16 || overflow !== 1'b1) begin
         bad++; $display("FAIL overflow_17: got c=%0d o=%b want c=16 o=1", count, overflow);
      end
      dataReady = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         total++;
         if (dataValid !== 1'b1 || data !== word_t'(i)) begin
            bad++; $display("FAIL drain_order: got v=%b d=%0d want v=1 d=%0d", dataValid, data, i);
         end
         tick();
      end
      total++;
      if (count !== 5'd0 || dataValid !== 1'b0 || overflow !== 1'b1) begin
         bad++; $display("FAIL drained_empty: got c=%0d v=%b o=%b want 0 0 1", count, dataValid, overflow);
      end
   endtask

   task automatic test_full_pop();
      pulse_run();
      dataReady = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         outWrite = 1'b1; outData = word_t'(i);
         tick();
      end
      outData = 12'd99; dataReady = 1'b1;
      tick();
      outWrite = 1'b0;
      total++;
      if (count !== 5'd16 || overflow !== 1'b0 || data !== 12'd2) begin
         bad++; $display("FAIL full_push_pop: got c=%0d o=%b d=%0d want c=16 o=0 d=2", count, overflow, data);
      end
      for (int i = 2; i <= 16; i++) begin
         tick();
      end
      total++;
      if (dataValid !== 1'b1 || data !== 12'd99 || count !== 5'd1) begin
         bad++; $display("FAIL last_is_99: got v=%b d=%0d c=%0d want v=1 d=99 c=1", dataValid, data, count);
      end
      tick();
      total++;
      if (count !== 5'd0) begin
         bad++; $display("FAIL full_pop_empty: got c=%0d want 0", count);
      end
   endtask

   task automatic test_hold();
      pulse_run();
      dataReady = 1'b0; outWrite = 1'b1; outData = 12'd7;
      tick();
      outWrite = 1'b0;
      for (int i = 0; i < 5; i++) begin
         total++;
         if (dataValid !== 1'b1 || data !== 12'd7) begin
            bad++; $display("FAIL hold_stable: got v=%b d=%0d want v=1 d=7", dataValid, data);
         end
         tick();
      end
      dataReady = 1'b1;
      tick();
      total++;
      if (dataValid !== 1'b0 || count !== 5'd0) begin
         bad++; $display("FAIL hold_pop: got v=%b c=%0d want 0 0", dataValid, count);
      end
   endtask

   task automatic test_reset_midrun();
      pulse_run();
      dataReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
         outWrite = 1'b1; outData = word_t'(40 + i);
         tick();
      end
      outWrite = 1'b0;
      total++;
      if (count !== 5'd3) begin
         bad++; $display("FAIL midrun_count: got c=%0d want 3", count);
      end
      reset = 1'b0;
      #2;
      total++;
      if ({dataValid, data, count, overflow, done} !== 19'd0) begin
         bad++; $display("FAIL async_reset: got v=%b d=%0d c=%0d o=%b dn=%b want all 0",
                         dataValid, data, count, overflow, done);
      end
      tick();
      reset = 1'b1;
      tick();
      outWrite = 1'b1; outData = 12'd55;
      tick();
      tick();
      outWrite = 1'b0;
      total++;
      if (count !== 5'd0 || dataValid !== 1'b0) begin
         bad++; $display("FAIL idle_ignores_push: got c=%0d v=%b want 0 0", count, dataValid);
      end
      pulse_run();
      outWrite = 1'b1; outData = 12'd55;
      tick();
      outWrite = 1'b0;
      total++;
      if (count !== 5'd1 || data !== 12'd55) begin
         bad++; $display("FAIL push_after_run: got c=%0d d=%0d want c=1 d=55", count, data);
      end
   endtask

`ifdef ZERO_OUT_CHECK_EN
   task automatic test_checker();
      logic [11:0] exp2;
      for (int pass = 0; pass < 2; pass++) begin
         pulse_run();
         total++;
         if (mismatches !== 5'd0 || success !== 1'b0) begin
            bad++; $display("FAIL chk_cleared: got m=%0d s=%b want 0 0", mismatches, success);
         end
         dataReady = 1'b0;
         outWrite = 1'b1; outData = 12'd2; tick();
         outData = 12'd5; tick();
         outWrite = 1'b0;
         exp2 = (pass == 0) ? 12'd4 : 12'd5;
         progFinished = 1'b1; dataReady = 1'b1; expectData = 12'd2;
         tick();
         expectData = exp2;
         tick();
         tick();
         total++;
         if (done !== 1'b1) begin
            bad++; $display("FAIL chk_done: got done=%b want 1", done);
         end
         total++;
         if (pass == 0 && (mismatches !== 5'd1 || success !== 1'b0)) begin
            bad++; $display("FAIL chk_mismatch: got m=%0d s=%b want m=1 s=0", mismatches, success);
         end else if (pass == 1 && (mismatches !== 5'd0 || success !== 1'b1)) begin
            bad++; $display("FAIL chk_success: got m=%0d s=%b want m=0 s=1", mismatches, success);
         end
         progFinished = 1'b0;
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_full_pop();
      test_hold();
      test_reset_midrun();
`ifdef ZERO_OUT_CHECK_EN
      test_checker();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
